// File: rtl/shape_cmd_queue_pkg.sv
// Shared definitions for the shape-processor command queue:
// the command field layout, the legal operation set and the legality screen.
package shape_cmd_pkg;

  localparam int SHAPE_LSB = 16;
  localparam int OP_LSB    = 0;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_START = 5'h01;
  localparam logic [4:0] OP_SCALE = 5'h08;
  localparam logic [4:0] OP_ROT   = 5'h10;
  localparam logic [4:0] OP_ROTSC = 5'h11;

  typedef struct packed {
    logic [1:0] shape;
    logic [4:0] operation;
  } shape_cmd_t;

  // Same rule the processor applies: one-hot shape and a known operation.
  function automatic bit is_legal_cmd(bit [31:0] cmd);
    bit [1:0] shape;
    bit [4:0] op;
    shape = cmd[SHAPE_LSB +: 2];
    op    = cmd[OP_LSB +: 5];
    return ((shape == 2'b01) || (shape == 2'b10)) &&
           ((op == OP_NOP) || (op == OP_START) || (op == OP_SCALE) ||
            (op == OP_ROT) || (op == OP_ROTSC));
  endfunction

endpackage

// File: rtl/shape_cmd_queue_if.sv
// Valid/ready command handshake between a command producer and the queue.
interface shape_cmd_queue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/shape_cmd_queue_fifo.sv
// Synchronous FIFO of screened commands; head is read straight from storage.
module shape_cmd_fifo
  import shape_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  shape_cmd_t             wdata_i,
  output shape_cmd_t             rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);

  shape_cmd_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    wptr_d  = push_i ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop_i  ? rptr_q + PTR_ONE : rptr_q;
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/shape_cmd_queue.sv
// Command queue ahead of the shape processor SFR port: screens commands,
// buffers legal ones and drains one registered write per cycle.
module shape_cmd_queue
  import shape_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shape_cmd_queue_if.slave       cmd,
  input  logic                   drain_en,
  output logic                   sfr_write,
  output logic [31:0]            sfr_write_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   illegal_cmd,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic             accept, legal, push, drop, pop;
  shape_cmd_t       wdata, head;
  logic [LW-1:0]    level_w;

  logic             sfr_write_q, sfr_write_d;
  logic [31:0]      sfr_data_q, sfr_data_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign cmd.cmd_ready = (level_w != FULL_LVL) && rst_n;

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign legal  = is_legal_cmd(cmd.cmd_data);
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = drain_en && (level_w != '0);

  assign wdata.shape     = cmd.cmd_data[SHAPE_LSB +: 2];
  assign wdata.operation = cmd.cmd_data[OP_LSB +: 5];

  shape_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .level_o (level_w)
  );

  always_comb begin
    sfr_write_d = pop;
    sfr_data_d  = pop ? {14'b0, head.shape, 11'b0, head.operation} : sfr_data_q;
    illegal_d   = drop;
    drop_d      = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sfr_write_q <= 1'b0;
      sfr_data_q  <= '0;
      illegal_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      sfr_write_q <= sfr_write_d;
      sfr_data_q  <= sfr_data_d;
      illegal_q   <= illegal_d;
      drop_q      <= drop_d;
    end
  end

  assign sfr_write      = sfr_write_q;
  assign sfr_write_data = sfr_data_q;
  assign level          = level_w;
  assign illegal_cmd    = illegal_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_shape_cmd_queue.sv
// Randomised and directed bench for shape_cmd_queue against a queue-based model.
module tb_shape_cmd_queue;
  import shape_cmd_pkg::*;

  localparam int DEPTH    = 4;
  localparam int CNT_W    = 2;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              drain_en;
  logic              sfr_write;
  logic [31:0]       sfr_write_data;
  logic [LW-1:0]     level;
  logic              illegal_cmd;
  logic [CNT_W-1:0]  drop_count;

  shape_cmd_queue_if cif ();

  shape_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd            (cif),
    .drain_en       (drain_en),
    .sfr_write      (sfr_write),
    .sfr_write_data (sfr_write_data),
    .level          (level),
    .illegal_cmd    (illegal_cmd),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: expected SFR words in FIFO order and expected outputs.
  logic [31:0] mq[$];
  bit          e_wr;
  logic [31:0] e_data;
  bit          e_ill;
  int          e_drop;
  bit          last_acc;
  int          wr_seen;
  int          max_lvl;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit ref_legal(input logic [31:0] d);
    int sh, op;
    sh = int'(d[17:16]);
    op = int'(d[4:0]);
    return (sh == 1 || sh == 2) && (op == 0 || op == 1 || op == 8 || op == 16 || op == 17);
  endfunction

  // One clock cycle: drive at negedge, check ready, advance model, check outputs at next negedge.
  task automatic cyc(input bit v, input logic [31:0] d, input bit dr, input bit rn = 1'b1);
    bit acc;
    cif.cmd_valid = v;
    cif.cmd_data  = d;
    drain_en      = dr;
    rst_n         = rn;
    #1;
    chk("cmd_ready", {31'b0, cif.cmd_ready}, {31'b0, rn && (mq.size() < DEPTH)});
    acc = v && rn && (mq.size() < DEPTH);
    last_acc = acc;
    if (!rn) begin
      mq.delete();
      e_wr = 0; e_data = '0; e_ill = 0; e_drop = 0;
    end else begin
      e_wr = 0;
      if (dr && mq.size() != 0) begin
        e_data = mq.pop_front();
        e_wr   = 1;
      end
      e_ill = acc && !ref_legal(d);
      if (acc && ref_legal(d)) mq.push_back(d & 32'h0003_001F);
      if (e_ill && e_drop < DROP_MAX) e_drop++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("level", 32'(level), 32'(mq.size()));
    chk("sfr_write", {31'b0, sfr_write}, {31'b0, e_wr});
    chk("sfr_write_data", sfr_write_data, e_data);
    chk("illegal_cmd", {31'b0, illegal_cmd}, {31'b0, e_ill});
    chk("drop_count", 32'(drop_count), 32'(e_drop));
    if (sfr_write) wr_seen++;
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0] ops [5];
    ops = '{5'h00, 5'h01, 5'h08, 5'h10, 5'h11};
    return ($urandom & 32'hFFFC_FFE0) | (32'($urandom_range(1, 2)) << 16) |
           32'(ops[$urandom_range(0, 4)]);
  endfunction

  initial begin
    int guard;
    int sat_seq [5];
    logic [31:0] fifth;
    sat_seq = '{1, 2, 3, 3, 3};
    cif.cmd_valid = 1'b0;
    cif.cmd_data  = '0;
    drain_en      = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    cyc(1'b1, 32'h0001_0000, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_sfr_data", sfr_write_data, 32'd0);

    // Legal command with upper bits scrubbed, two-cycle latency.
    cyc(1'b1, 32'hABCD_0010, 1'b1);
    chk("t1_level_n1", 32'(level), 32'd1);
    chk("t1_wr_n1", {31'b0, sfr_write}, 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("t1_wr_n2", {31'b0, sfr_write}, 32'd1);
    chk("t1_data_n2", sfr_write_data, 32'h0001_0010);
    cyc(1'b0, '0, 1'b1);

    // Illegal commands are dropped and counted.
    cyc(1'b1, 32'h0003_0000, 1'b1);
    chk("t2_ill1", {31'b0, illegal_cmd}, 32'd1);
    cyc(1'b1, 32'h0001_0009, 1'b1);
    chk("t2_ill2", {31'b0, illegal_cmd}, 32'd1);
    cyc(1'b0, '0, 1'b1);
    chk("t2_drop", 32'(drop_count), 32'd2);
    chk("t2_ready", {31'b0, cif.cmd_ready}, 32'd1);

    // Fill while stalled, hold a fifth command, then drain in order.
    cyc(1'b1, 32'h0001_0000, 1'b0);
    cyc(1'b1, 32'h0002_0001, 1'b0);
    cyc(1'b1, 32'h0001_0008, 1'b0);
    cyc(1'b1, 32'h0002_0011, 1'b0);
    fifth = 32'h0001_0001;
    cyc(1'b1, fifth, 1'b0);
    cyc(1'b1, fifth, 1'b0);
    chk("t3_full_level", 32'(level), 32'd4);
    chk("t3_full_ready", {31'b0, cif.cmd_ready}, 32'd0);
    wr_seen = 0;
    guard = 0;
    do begin
      cyc(1'b1, fifth, 1'b1);
      guard++;
    end while (!last_acc && guard < 10);
    chk("t3_fifth_after", 32'(guard), 32'd2);
    repeat (6) cyc(1'b0, '0, 1'b1);
    chk("t3_writes", 32'(wr_seen), 32'd5);

    // Wrap with concurrent push and pop.
    wr_seen = 0;
    max_lvl = 0;
    for (int i = 0; i < 12; i++) cyc(1'b1, rand_legal(), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("t4_writes", 32'(wr_seen), 32'd12);
    chk("t4_max_level", 32'(max_lvl), 32'd1);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) cyc(1'b1, rand_legal(), 1'b0);
    chk("t5_pre_level", 32'(level), 32'd3);
    cyc(1'b1, rand_legal(), 1'b1, 1'b0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_wr", {31'b0, sfr_write}, 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("t5_ready_after", {31'b0, cif.cmd_ready}, 32'd1);

    // Drop counter saturation.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h0003_0000 | 32'($urandom_range(0, 31)), 1'b1);
      chk("t6_ill", {31'b0, illegal_cmd}, 32'd1);
      chk("t6_drop", 32'(drop_count), 32'(sat_seq[i]));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 9) < 6) ? rand_legal() : $urandom;
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
          $urandom_range(0, 60) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shape_cmd_queue.md
Name: shape_cmd_queue

Overview:
Command buffer directly upstream of the shape processor's control-SFR write port. It accepts 32-bit control commands over a valid/ready handshake and pre-screens them with the same legality rules the processor applies. Legal commands are buffered in a FIFO and drained one write per cycle into the processor. Illegal commands are dropped, counted and flagged, so software sees rejections that the processor itself ignores silently.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_W, 8, width of drop counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  queue can accept this cycle
cmd_data  in  32  command; [17:16] shape, [4:0] operation, other bits ignored
drain_en  in  1  downstream allows writes; 0 stalls draining
sfr_write  out  1  write strobe to shape processor
sfr_write_data  out  32  write data to shape processor
level  out  $clog2(DEPTH)+1  current FIFO occupancy
illegal_cmd  out  1  one-cycle pulse: an illegal command was dropped
drop_count  out  CNT_W  saturating count of dropped commands

Behaviour:
- Legal command: shape is one-hot (01 or 10) AND operation is in {5'h00, 5'h01, 5'h08, 5'h10, 5'h11}. Everything else is illegal.
- Accept: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (level != DEPTH) && rst_n. It is combinational from registered state only.
- Accepted legal command: pushes {shape, operation} (7 bits) into the FIFO. The pushed entry is visible in level the next cycle.
- Accepted illegal command: not pushed. illegal_cmd = 1 in the next cycle only. drop_count increments and saturates at all-ones.
- Drain: in each cycle with drain_en && level != 0, pop the head. The next cycle then has sfr_write = 1 and sfr_write_data = {14'b0, shape, 11'b0, operation}. Otherwise sfr_write = 0 next cycle and sfr_write_data holds its last value.
- Latency: a legal command accepted in cycle N into an empty FIFO with drain_en = 1 produces sfr_write in cycle N+2. There is no bypass path.
- Throughput: back-to-back accepts and back-to-back sfr_write cycles are both sustained at 1 per cycle.
- Push and pop in the same cycle: both are performed and level is unchanged.
- When full, no push occurs even if a pop happens in the same cycle, because cmd_ready does not depend on the pop.
- Ordering: strict FIFO order. Read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from level.
- Reset (rst_n = 0 at a clock edge): level = 0, pointers = 0, sfr_write = 0, sfr_write_data = 0, illegal_cmd = 0, drop_count = 0. cmd_ready = 0 while rst_n = 0.
- Reset mid-operation: buffered entries are discarded. No sfr_write occurs in the cycle after the reset edge. A command presented during reset is not accepted.
- No state machine beyond FIFO occupancy; the block is pipelined, not multi-phase.

Decomposition:
- Package shape_cmd_pkg contains:
  - field positions SHAPE_LSB = 16 and OP_LSB = 0;
  - the legal operation constants;
  - a packed struct shape_cmd_t {shape[1:0], operation[4:0]};
  - function is_legal_cmd(bit [31:0]) returning bit.
- Sub-module shape_cmd_fifo: synchronous FIFO of shape_cmd_t, parameter DEPTH, with push/pop/level, registered storage and no output register.
- The top level holds the legality screen, the output register, illegal_cmd and drop_count.

Test Plan:
- Legal command, upper bits scrubbed: empty queue, drain_en = 1, cmd_data 32'hABCD_0010 accepted in cycle N -> sfr_write = 1 only in N+2 with sfr_write_data 32'h0001_0010; level = 1 in N+1 and 0 in N+2.
- Illegal commands: 32'h0003_0000 (shape 11) then 32'h0001_0009 (op 01_001) -> illegal_cmd pulses in the cycle after each accept; drop_count ends at 2; level stays 0; no sfr_write; cmd_ready remains 1.
- Fill and stall: DEPTH = 4, drain_en = 0, push 32'h0001_0000, 32'h0002_0001, 32'h0001_0008, 32'h0002_0011 -> level = 4, cmd_ready = 0, a fifth valid command is held (not accepted). Raise drain_en -> four consecutive sfr_write cycles with data 32'h0001_0000, 32'h0002_0001, 32'h0001_0008, 32'h0002_0011, in order; the fifth command is accepted the cycle after level drops to 3.
- Wrap and concurrency: drain_en = 1, 12 back-to-back legal commands -> 12 consecutive sfr_write cycles, in order, starting 2 cycles after the first accept; level never exceeds 1.
- Reset mid-operation: level = 3 with drain_en = 0, rst_n = 0 for one edge -> next cycle level = 0, sfr_write = 0, drop_count = 0, cmd_ready = 0 while reset is low and 1 afterwards.
- Saturation: CNT_W = 2, 5 illegal commands -> drop_count sequence 1, 2, 3, 3, 3; illegal_cmd pulses 5 times.
